// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared types and constants for the video mode controller.
//   - Mode codes for the three supported resolutions (code 3 is illegal).
//   - timing_t: packed timing set driven to the pattern generator.
//   - state_e: controller FSM states.
//   - timing_for_mode(): mode code -> timing set lookup.
package video_timing_pkg;

    localparam logic [1:0] MODE_800x600  = 2'd0;
    localparam logic [1:0] MODE_1024x768 = 2'd1;
    localparam logic [1:0] MODE_1280x720 = 2'd2;
    localparam logic [1:0] MODE_ILLEGAL  = 2'd3;

    typedef struct packed {
        logic [11:0] h_total;
        logic [11:0] h_sync;
        logic [11:0] h_bporch;
        logic [11:0] h_res;
        logic [11:0] v_total;
        logic [11:0] v_sync;
        logic [11:0] v_bporch;
        logic [11:0] v_res;
    } timing_t;

    typedef enum logic [1:0] {
        StHold,
        StIdle,
        StWaitFrame
    } state_e;

    function automatic timing_t timing_for_mode(input logic [1:0] mode);
        timing_t t;
        case (mode)
            MODE_800x600: begin
                t = '{h_total: 12'd1056, h_sync: 12'd128, h_bporch: 12'd88, h_res: 12'd800,
                      v_total: 12'd628, v_sync: 12'd4, v_bporch: 12'd23, v_res: 12'd600};
            end
            MODE_1024x768: begin
                t = '{h_total: 12'd1344, h_sync: 12'd136, h_bporch: 12'd160, h_res: 12'd1024,
                      v_total: 12'd806, v_sync: 12'd6, v_bporch: 12'd29, v_res: 12'd768};
            end
            // 1280x720, also used as a safe fallback for the illegal code
            default: begin
                t = '{h_total: 12'd1650, h_sync: 12'd40, h_bporch: 12'd220, h_res: 12'd1280,
                      v_total: 12'd750, v_sync: 12'd5, v_bporch: 12'd20, v_res: 12'd720};
            end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/video_mode_ctrl_if.sv
// video_mode_ctrl_if: mode-change request handshake (valid/ready).
//   I_mode_valid : request valid (requester -> controller)
//   I_mode       : requested mode code
//   O_mode_ready : controller can accept a request
// Modports: master = requester side, slave = controller side.
interface video_mode_ctrl_if;
    logic       I_mode_valid;
    logic [1:0] I_mode;
    logic       O_mode_ready;

    modport master (
        output I_mode_valid,
        output I_mode,
        input  O_mode_ready
    );

    modport slave (
        input  I_mode_valid,
        input  I_mode,
        output O_mode_ready
    );
endinterface

// File: rtl/vs_frame_edge.sv
// vs_frame_edge: normalises VS polarity, registers it and flags the frame end.
//   clk, rst    : pixel clock, asynchronous active-high reset
//   vs_i        : raw VS from the generator
//   frame_end_o : high in the first cycle the registered VS sample is inactive
//                 after having been active
module vs_frame_edge #(
    parameter bit VS_POL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic vs_i,
    output logic frame_end_o
);

    logic vs_d, vs_q;
    logic vs_prev_d, vs_prev_q;

    always_comb begin
        vs_d      = VS_POL ? vs_i : ~vs_i;
        vs_prev_d = vs_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            vs_q      <= vs_d;
            vs_prev_q <= vs_prev_d;
        end
    end

    assign frame_end_o = vs_prev_q & ~vs_q;

endmodule

// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl: frame-synchronous timing/mode controller for the test-pattern generator.
//   I_pxl_clk, I_rst : pixel clock, asynchronous active-high reset
//   I_vs             : VS from the generator (polarity set by VS_POL)
//   mode_if          : mode request handshake (slave side)
//   O_tp_rst_n       : generator reset, held low around each mode switch
//   O_h_* / O_v_*    : timing set of the current mode
//   O_hs_pol/vs_pol  : sync polarities (always 1)
//   O_pattern_sel    : test-pattern index
//   O_frame_cnt      : frame ends since the last switch
//   O_done / O_err   : one-cycle pulses: switch complete / illegal mode accepted
// Optional feature: VIDEO_MODE_CTRL_AUTO_CYCLE_EN enables pattern auto-advance every
// FRAMES_PER_PATTERN frame ends; without it O_pattern_sel is tied to 0.
module video_mode_ctrl
    import video_timing_pkg::*;
#(
    parameter int unsigned DEFAULT_MODE       = 2,
    parameter int unsigned RST_CYCLES         = 16,
    parameter int unsigned FRAMES_PER_PATTERN = 60,
    parameter int unsigned NUM_PATTERNS       = 4,
    parameter bit          VS_POL             = 1'b1
) (
    input  logic               I_pxl_clk,
    input  logic               I_rst,
    input  logic               I_vs,
    video_mode_ctrl_if.slave   mode_if,
    output logic               O_tp_rst_n,
    output logic [11:0]        O_h_total,
    output logic [11:0]        O_h_sync,
    output logic [11:0]        O_h_bporch,
    output logic [11:0]        O_h_res,
    output logic [11:0]        O_v_total,
    output logic [11:0]        O_v_sync,
    output logic [11:0]        O_v_bporch,
    output logic [11:0]        O_v_res,
    output logic               O_hs_pol,
    output logic               O_vs_pol,
    output logic [2:0]         O_pattern_sel,
    output logic [15:0]        O_frame_cnt,
    output logic               O_done,
    output logic               O_err
);

    if (DEFAULT_MODE > 2 || RST_CYCLES == 0 || RST_CYCLES > 255 ||
        FRAMES_PER_PATTERN == 0 || FRAMES_PER_PATTERN > 65535 ||
        NUM_PATTERNS == 0 || NUM_PATTERNS > 8) begin : g_param_check
        $error("video_mode_ctrl: parameter out of legal range");
    end

    localparam logic [7:0] HoldLast       = 8'(RST_CYCLES - 1);
    localparam timing_t    DefaultTiming  = timing_for_mode(2'(DEFAULT_MODE));

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  mode_lat_q, mode_lat_d;
    timing_t     timing_q, timing_d;
    logic        tp_rst_n_q, tp_rst_n_d;
    logic        mode_ready_q, mode_ready_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic frame_end_raw;
    logic frame_end;
    logic accept;

    vs_frame_edge #(
        .VS_POL (VS_POL)
    ) u_vs_frame_edge (
        .clk         (I_pxl_clk),
        .rst         (I_rst),
        .vs_i        (I_vs),
        .frame_end_o (frame_end_raw)
    );

    // Frame ends are ignored while the generator is held in reset.
    assign frame_end = frame_end_raw & tp_rst_n_q;
    assign accept    = mode_if.I_mode_valid & mode_ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_lat_d  = mode_lat_q;
        timing_d    = timing_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (frame_end) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        case (state_q)
            StHold: begin
                if (cnt_q == HoldLast) begin
                    state_d     = StIdle;
                    done_d      = 1'b1;
                    frame_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StIdle: begin
                if (accept) begin
                    if (mode_if.I_mode == MODE_ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        mode_lat_d = mode_if.I_mode;
                        state_d    = StWaitFrame;
                    end
                end
            end
            StWaitFrame: begin
                if (frame_end) begin
                    timing_d = timing_for_mode(mode_lat_q);
                    state_d  = StHold;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = StHold;
                cnt_d   = '0;
            end
        endcase

        // Registered outputs are derived from the next state so they line up with it.
        tp_rst_n_d   = (state_d != StHold);
        mode_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge I_pxl_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q      <= StHold;
            cnt_q        <= '0;
            mode_lat_q   <= 2'(DEFAULT_MODE);
            timing_q     <= DefaultTiming;
            tp_rst_n_q   <= 1'b0;
            mode_ready_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_lat_q   <= mode_lat_d;
            timing_q     <= timing_d;
            tp_rst_n_q   <= tp_rst_n_d;
            mode_ready_q <= mode_ready_d;
            done_q       <= done_d;
            err_q        <= err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

`ifdef VIDEO_MODE_CTRL_AUTO_CYCLE_EN
    localparam logic [15:0] PatLast = 16'(FRAMES_PER_PATTERN - 1);
    localparam logic [2:0]  SelLast = 3'(NUM_PATTERNS - 1);

    logic [15:0] pat_cnt_q, pat_cnt_d;
    logic [2:0]  pat_sel_q, pat_sel_d;

    always_comb begin
        pat_cnt_d = pat_cnt_q;
        pat_sel_d = pat_sel_q;
        // done_d marks the HOLD exit; it never coincides with a recognised frame end.
        if (done_d) begin
            pat_cnt_d = '0;
            pat_sel_d = '0;
        end else if (frame_end) begin
            if (pat_cnt_q == PatLast) begin
                pat_cnt_d = '0;
                pat_sel_d = (pat_sel_q == SelLast) ? 3'd0 : pat_sel_q + 3'd1;
            end else begin
                pat_cnt_d = pat_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge I_pxl_clk or posedge I_rst) begin
        if (I_rst) begin
            pat_cnt_q <= '0;
            pat_sel_q <= '0;
        end else begin
            pat_cnt_q <= pat_cnt_d;
            pat_sel_q <= pat_sel_d;
        end
    end

    assign O_pattern_sel = pat_sel_q;
`else
    assign O_pattern_sel = 3'd0;
`endif

    assign mode_if.O_mode_ready = mode_ready_q;
    assign O_tp_rst_n           = tp_rst_n_q;
    assign O_h_total            = timing_q.h_total;
    assign O_h_sync             = timing_q.h_sync;
    assign O_h_bporch           = timing_q.h_bporch;
    assign O_h_res              = timing_q.h_res;
    assign O_v_total            = timing_q.v_total;
    assign O_v_sync             = timing_q.v_sync;
    assign O_v_bporch           = timing_q.v_bporch;
    assign O_v_res              = timing_q.v_res;
    assign O_hs_pol             = 1'b1;
    assign O_vs_pol             = 1'b1;
    assign O_frame_cnt          = frame_cnt_q;
    assign O_done               = done_q;
    assign O_err                = err_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb_video_mode_ctrl: directed self-checking bench for video_mode_ctrl.
// Instantiated with FRAMES_PER_PATTERN = 2, NUM_PATTERNS = 3, other parameters default.
module tb_video_mode_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vs  = 1'b0;
    logic        tp_rst_n, hs_pol, vs_pol, done, err;
    logic [11:0] h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res;
    logic [2:0]  pattern_sel;
    logic [15:0] frame_cnt;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [95:0] T800  = {12'd1056, 12'd128, 12'd88, 12'd800,
                                     12'd628, 12'd4, 12'd23, 12'd600};
    localparam logic [95:0] T1024 = {12'd1344, 12'd136, 12'd160, 12'd1024,
                                     12'd806, 12'd6, 12'd29, 12'd768};
    localparam logic [95:0] T1280 = {12'd1650, 12'd40, 12'd220, 12'd1280,
                                     12'd750, 12'd5, 12'd20, 12'd720};

    logic [95:0] tset;
    assign tset = {h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res};

    video_mode_ctrl_if mif ();

    video_mode_ctrl #(
        .DEFAULT_MODE       (2),
        .RST_CYCLES         (16),
        .FRAMES_PER_PATTERN (2),
        .NUM_PATTERNS       (3),
        .VS_POL             (1'b1)
    ) dut (
        .I_pxl_clk     (clk),
        .I_rst         (rst),
        .I_vs          (vs),
        .mode_if       (mif),
        .O_tp_rst_n    (tp_rst_n),
        .O_h_total     (h_total),
        .O_h_sync      (h_sync),
        .O_h_bporch    (h_bporch),
        .O_h_res       (h_res),
        .O_v_total     (v_total),
        .O_v_sync      (v_sync),
        .O_v_bporch    (v_bporch),
        .O_v_res       (v_res),
        .O_hs_pol      (hs_pol),
        .O_vs_pol      (vs_pol),
        .O_pattern_sel (pattern_sel),
        .O_frame_cnt   (frame_cnt),
        .O_done        (done),
        .O_err         (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns in cycle E: the first cycle whose registered VS sample is inactive.
    task automatic vs_fall();
        vs = 1'b1;
        step();
        step();
        vs = 1'b0;
        step();
    endtask

    // Checks the 15 remaining low cycles of a hold, then the release cycle.
    task automatic hold_and_release(input string name);
        for (int i = 0; i < 15; i++) begin
            step();
            n_cmp++;
            if (tp_rst_n !== 1'b0) begin
                n_err++;
                $display("FAIL %s_hold[%0d]: tp_rst_n=%b want 0", name, i, tp_rst_n);
            end
        end
        step();
        n_cmp++;
        if ({tp_rst_n, done, mif.O_mode_ready} !== 3'b111) begin
            n_err++;
            $display("FAIL %s_release: tp_rst_n/done/ready=%b want 111", name,
                     {tp_rst_n, done, mif.O_mode_ready});
        end
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++;
        if ({tp_rst_n, mif.O_mode_ready, done, err} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl: rst_n/ready/done/err=%b want 0000",
                     {tp_rst_n, mif.O_mode_ready, done, err});
        end
        n_cmp++;
        if ({pattern_sel, frame_cnt} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_cnt: sel=%0d frame_cnt=%0d want 0/0", pattern_sel, frame_cnt);
        end
        n_cmp++;
        if (tset !== T1280 || {hs_pol, vs_pol} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_timing: set=%h pol=%b want %h 11", tset, {hs_pol, vs_pol}, T1280);
        end
        rst = 1'b0;
        hold_and_release("reset");
        step();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_done_pulse: done=%b want 0", done);
        end
    endtask

    task automatic test_mode_switch();
        mif.I_mode_valid = 1'b1;
        mif.I_mode       = 2'd0;
        step();
        mif.I_mode_valid = 1'b0;
        n_cmp++;
        if (mif.O_mode_ready !== 1'b0) begin
            n_err++;
            $display("FAIL switch_ready_drop: ready=%b want 0", mif.O_mode_ready);
        end
        for (int i = 0; i < 3; i++) step();
        vs_fall();
        n_cmp++;
        if (tset !== T1280 || tp_rst_n !== 1'b1) begin
            n_err++;
            $display("FAIL switch_before_e1: set=%h rst_n=%b want %h 1", tset, tp_rst_n, T1280);
        end
        step();
        n_cmp++;
        if (tset !== T800 || tp_rst_n !== 1'b0 || mif.O_mode_ready !== 1'b0) begin
            n_err++;
            $display("FAIL switch_e1: set=%h rst_n=%b ready=%b want %h 0 0",
                     tset, tp_rst_n, mif.O_mode_ready, T800);
        end
        hold_and_release("switch");
        n_cmp++;
        if (frame_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL switch_frame_cnt: got %0d want 0", frame_cnt);
        end
    endtask

    task automatic test_illegal();
        vs_fall();
        step();
        n_cmp++;
        if (frame_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL idle_frame_cnt: got %0d want 1", frame_cnt);
        end
        mif.I_mode_valid = 1'b1;
        mif.I_mode       = 2'd3;
        step();
        mif.I_mode_valid = 1'b0;
        n_cmp++;
        if (err !== 1'b1 || mif.O_mode_ready !== 1'b1 || tset !== T800 || frame_cnt !== 16'd1)
        begin
            n_err++;
            $display("FAIL illegal_accept: err=%b ready=%b set=%h cnt=%0d want 1 1 %h 1",
                     err, mif.O_mode_ready, tset, frame_cnt, T800);
        end
        step();
        n_cmp++;
        if (err !== 1'b0 || mif.O_mode_ready !== 1'b1 || tp_rst_n !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_after: err=%b ready=%b rst_n=%b want 0 1 1",
                     err, mif.O_mode_ready, tp_rst_n);
        end
    endtask

    task automatic test_back_to_back();
        mif.I_mode_valid = 1'b1;
        mif.I_mode       = 2'd1;
        step();
        mif.I_mode = 2'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (mif.O_mode_ready !== 1'b0 || err !== 1'b0) begin
                n_err++;
                $display("FAIL held_valid[%0d]: ready=%b err=%b want 0 0",
                         i, mif.O_mode_ready, err);
            end
        end
        mif.I_mode_valid = 1'b0;
        vs_fall();
        step();
        n_cmp++;
        if (tset !== T1024) begin
            n_err++;
            $display("FAIL held_valid_mode: set=%h want %h", tset, T1024);
        end
        hold_and_release("b2b_first");
        mif.I_mode_valid = 1'b1;
        mif.I_mode       = 2'd2;
        step();
        mif.I_mode_valid = 1'b0;
        n_cmp++;
        if (mif.O_mode_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second_accept: ready=%b want 0", mif.O_mode_ready);
        end
        vs_fall();
        step();
        n_cmp++;
        if (tset !== T1280 || tp_rst_n !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second_mode: set=%h rst_n=%b want %h 0", tset, tp_rst_n, T1280);
        end
        hold_and_release("b2b_second");
    endtask

    task automatic test_pattern();
        logic [2:0] exp_sel [7];
`ifdef VIDEO_MODE_CTRL_AUTO_CYCLE_EN
        exp_sel = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd0, 3'd0};
`else
        exp_sel = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`endif
        for (int k = 0; k < 7; k++) begin
            vs_fall();
            step();
            n_cmp++;
            if (pattern_sel !== exp_sel[k] || frame_cnt !== 16'(k + 1)) begin
                n_err++;
                $display("FAIL pattern[%0d]: sel=%0d cnt=%0d want %0d %0d",
                         k, pattern_sel, frame_cnt, exp_sel[k], k + 1);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        mif.I_mode_valid = 1'b1;
        mif.I_mode       = 2'd1;
        step();
        mif.I_mode_valid = 1'b0;
        vs_fall();
        step();
        n_cmp++;
        if (tset !== T1024 || tp_rst_n !== 1'b0) begin
            n_err++;
            $display("FAIL abort_e1: set=%h rst_n=%b want %h 0", tset, tp_rst_n, T1024);
        end
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (tset !== T1280 || {tp_rst_n, mif.O_mode_ready, frame_cnt} !== 18'd0) begin
            n_err++;
            $display("FAIL abort_reset: set=%h rst_n=%b ready=%b cnt=%0d want %h 0 0 0",
                     tset, tp_rst_n, mif.O_mode_ready, frame_cnt, T1280);
        end
        step();
        step();
        rst = 1'b0;
        hold_and_release("abort");
        vs_fall();
        step();
        n_cmp++;
        if (tp_rst_n !== 1'b1 || tset !== T1280 || mif.O_mode_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort_request_lost: rst_n=%b set=%h ready=%b want 1 %h 1",
                     tp_rst_n, tset, mif.O_mode_ready, T1280);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mif.I_mode_valid = 1'b0;
        mif.I_mode       = 2'd0;
        test_reset();
        test_mode_switch();
        test_illegal();
        test_back_to_back();
        test_pattern();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
